signature_compactor: RTL and testbench
======================================

SIGNATURE_COMPACTOR -- requirements
Module: signature_compactor

Interface
REQ-001 Parameter DATA_WIDTH, default 128, width of observed data; SHALL be a positive multiple of 32.
REQ-002 Parameter WARMUP_CYCLES, default 64, cycles discarded after start; 0 is legal.
REQ-003 Parameter RUN_CYCLES, default 1024, cycles compacted per run; SHALL be 1..65535.
REQ-004 Parameter SEED, default 32'hFFFFFFFF, initial signature value.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle run request.
REQ-008 data_in  input  DATA_WIDTH  observed data, e.g. concatenated pipeline outputs.
REQ-009 signature  output  32  registered MISR value.
REQ-010 busy  output  1  high in WARMUP and COMPACT.
REQ-011 done  output  1  high in DONE.
REQ-012 cycle_count  output  16  registered position within the current phase.

Function
REQ-013 The block SHALL be a four-state FSM: IDLE, WARMUP, COMPACT, DONE.
REQ-014 In IDLE or DONE, start SHALL load signature to SEED and cycle_count to 0, and enter WARMUP, or COMPACT if WARMUP_CYCLES is 0.
REQ-015 start SHALL be ignored while busy is high.
REQ-016 In WARMUP, data_in SHALL be ignored, cycle_count SHALL increment each cycle, and the FSM SHALL enter COMPACT with cycle_count cleared on the cycle cycle_count equals WARMUP_CYCLES-1.
REQ-017 Folding: fold SHALL be the XOR of all DATA_WIDTH/32 32-bit slices of data_in.
REQ-018 In COMPACT, each cycle SHALL update signature to {signature[30:0], fb} XOR fold, where fb = signature[31]^signature[21]^signature[1]^signature[0].
REQ-019 In COMPACT, cycle_count SHALL increment each cycle; the cycle cycle_count equals RUN_CYCLES-1 SHALL perform the final update and enter DONE.
REQ-020 Exactly RUN_CYCLES updates SHALL occur per run, sampling data_in on those same edges with no extra latency.
REQ-021 In DONE, signature and cycle_count SHALL hold, and done SHALL remain high until start or reset.
REQ-022 In IDLE, signature SHALL hold.
REQ-023 busy and done SHALL decode from the registered state only and SHALL never be high simultaneously.
REQ-024 cycle_count SHALL never wrap within a phase.

Reset
REQ-025 When reset is high, the next edge SHALL force: state IDLE, signature SEED, cycle_count 0, busy 0, done 0.
REQ-026 Reset SHALL take priority over start and over any in-progress run; a mid-run reset SHALL discard the partial signature.
REQ-027 After reset is released, the block SHALL remain in IDLE until start.

Structure
REQ-028 A shared package SHALL hold the state enum, the MISR tap constants (31, 21, 1, 0), and the default SEED.
REQ-029 The signature-update step SHALL be one combinational sub-module, misr32_step: inputs current signature and fold, output next signature.
REQ-030 The fold SHALL be a parameterized generate loop inside signature_compactor.

Verification
REQ-031 Scenario: SEED=0, WARMUP=0, RUN=2; start, then data_in slice0 = 1 then 0, with all other slices 0 -> signature 0x00000001 after the first update, 0x00000003 after the second; done rises, busy falls.
REQ-032 Scenario: SEED=0, data_in all zero, RUN=1024 -> signature stays 0x00000000; done after exactly 1024 COMPACT cycles.
REQ-033 Scenario: WARMUP=64, random data during warmup, then zeros with SEED=0 -> final signature 0x00000000, proving warmup data is ignored.
REQ-034 Scenario: start pulsed mid-COMPACT -> no restart; cycle_count continues; signature matches the reference model.
REQ-035 Scenario: reset asserted at COMPACT cycle 500 -> next cycle IDLE, signature = SEED, busy 0; a new start gives a result identical to a clean run.
REQ-036 Scenario: DATA_WIDTH=128, random data, two back-to-back runs with start in DONE -> each run reloads SEED and both signatures match the software MISR model.

Source files
------------

// File: rtl/signature_compactor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : signature_compactor_pkg
// Brief    : Shared types and constants for the signature compactor: FSM
//            state encoding, MISR feedback taps and the default seed.
// Revision : 1.0 - initial release
// ============================================================================
package signature_compactor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WARMUP  = 2'd1,
      ST_COMPACT = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Feedback taps of the 32-bit MISR polynomial
   localparam int unsigned C_TAP_3 = 31;
   localparam int unsigned C_TAP_2 = 21;
   localparam int unsigned C_TAP_1 = 1;
   localparam int unsigned C_TAP_0 = 0;

   localparam logic [31:0] C_DEFAULT_SEED = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/signature_compactor_misr32_step.sv
`default_nettype none
// ============================================================================
// Module   : misr32_step
// Brief    : One combinational MISR update: shift left, insert the tap
//            feedback bit at bit 0, then XOR in the folded data word.
// Revision : 1.0 - initial release
// ============================================================================
module misr32_step
   import signature_compactor_pkg::*;
(
   input  logic [31:0] i_sig,
   input  logic [31:0] i_fold,
   output logic [31:0] o_next
);

   logic w_fb;

   assign w_fb   = i_sig[C_TAP_3] ^ i_sig[C_TAP_2] ^ i_sig[C_TAP_1] ^ i_sig[C_TAP_0];
   assign o_next = {i_sig[30:0], w_fb} ^ i_fold;

endmodule
`default_nettype wire

// File: rtl/signature_compactor.sv
`default_nettype none
// ============================================================================
// Module   : signature_compactor
// Brief    : Run-controlled MISR signature compactor. A start request loads
//            the seed, skips WARMUP_CYCLES of data, then folds data_in into
//            the signature for exactly RUN_CYCLES cycles and parks in DONE.
// Revision : 1.0 - initial release
// ============================================================================
module signature_compactor
   import signature_compactor_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 128,
   parameter int unsigned WARMUP_CYCLES = 64,
   parameter int unsigned RUN_CYCLES    = 1024,
   parameter logic [31:0] SEED          = C_DEFAULT_SEED
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [31:0]           signature,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           cycle_count
);

   localparam int unsigned C_SLICES      = DATA_WIDTH / 32;
   // Only compared while in the matching phase, so the WARMUP_CYCLES=0
   // wrap to 16'hFFFF is never observed.
   localparam logic [15:0] C_WARMUP_LAST = 16'(WARMUP_CYCLES - 1);
   localparam logic [15:0] C_RUN_LAST    = 16'(RUN_CYCLES - 1);
   localparam state_t      C_FIRST_STATE = (WARMUP_CYCLES == 0) ? ST_COMPACT : ST_WARMUP;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_signature;
   logic [31:0] w_sig_next;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_next;
   logic [31:0] w_fold;
   logic [31:0] w_misr_next;
   logic [31:0] w_slice [C_SLICES];

   // Split data_in into its 32-bit slices
   generate
      for (genvar gi = 0; gi < int'(C_SLICES); gi++) begin : g_fold
         assign w_slice[gi] = data_in[gi*32 +: 32];
      end
   endgenerate

   // XOR all slices together into a single 32-bit fold word
   always_comb begin
      w_fold = '0;
      for (int i = 0; i < int'(C_SLICES); i++) begin
         w_fold = w_fold ^ w_slice[i];
      end
   end

   misr32_step u_misr (
      .i_sig  (r_signature),
      .i_fold (w_fold),
      .o_next (w_misr_next)
   );

   // Next-state, next-signature and next-count decode
   always_comb begin
      w_state_next = r_state;
      w_sig_next   = r_signature;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_next = C_FIRST_STATE;
               w_sig_next   = SEED;
               w_cnt_next   = '0;
            end
         end
         ST_WARMUP: begin
            if (r_cnt == C_WARMUP_LAST) begin
               w_state_next = ST_COMPACT;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 16'd1;
            end
         end
         ST_COMPACT: begin
            w_sig_next = w_misr_next;
            // The last compacted position is held through DONE
            if (r_cnt == C_RUN_LAST) begin
               w_state_next = ST_DONE;
            end else begin
               w_cnt_next = r_cnt + 16'd1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State, signature and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_signature <= SEED;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_next;
         r_signature <= w_sig_next;
         r_cnt       <= w_cnt_next;
      end
   end

   assign signature   = r_signature;
   assign cycle_count = r_cnt;
   assign busy        = (r_state == ST_WARMUP) || (r_state == ST_COMPACT);
   assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_signature_compactor.sv
`default_nettype none
// ============================================================================
// Module   : tb_signature_compactor
// Brief    : Self-checking bench for signature_compactor with three parameter
//            sets: a tiny RUN=2 table-driven instance, a zero-seed long run,
//            and a default-parameter instance checked against a MISR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signature_compactor;

   logic         clk = 1'b0;
   logic         reset;
   logic         start_a, start_b, start_c;
   logic [127:0] data_a, data_b, data_c;
   logic [31:0]  sig_a, sig_b, sig_c;
   logic         busy_a, busy_b, busy_c;
   logic         done_a, done_b, done_c;
   logic [15:0]  cnt_a, cnt_b, cnt_c;

   int n_vec = 0;
   int n_bad = 0;
   logic [31:0] sb_q [$];

   always #5 clk = ~clk;

   signature_compactor #(.DATA_WIDTH(128), .WARMUP_CYCLES(0), .RUN_CYCLES(2), .SEED(32'h0)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .data_in(data_a),
      .signature(sig_a), .busy(busy_a), .done(done_a), .cycle_count(cnt_a));

   signature_compactor #(.DATA_WIDTH(128), .WARMUP_CYCLES(64), .RUN_CYCLES(1024), .SEED(32'h0)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .data_in(data_b),
      .signature(sig_b), .busy(busy_b), .done(done_b), .cycle_count(cnt_b));

   signature_compactor u_dut_c (
      .clk(clk), .reset(reset), .start(start_c), .data_in(data_c),
      .signature(sig_c), .busy(busy_c), .done(done_c), .cycle_count(cnt_c));

   typedef struct {
      logic         rst;
      logic         st;
      logic [127:0] d;
      logic [31:0]  sig;
      logic         busy;
      logic         done;
      logic [15:0]  cnt;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_fold(input logic [127:0] d);
      return d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
   endfunction

   function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] f);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return {s[30:0], fb} ^ f;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Full run on the default instance; rst_at / mid_start_at select a
   // compact-phase index for a reset or an ignored start (-1 = none).
   task automatic run_c(input int rst_at, input int mid_start_at);
      logic [31:0]  m;
      logic [127:0] d;
      start_c = 1'b1;
      data_c  = rand128();
      @(posedge clk); #1;
      start_c = 1'b0;
      chk("c_seed_load", sig_c, 32'hFFFF_FFFF);
      chk("c_busy_start", {31'b0, busy_c}, 32'd1);
      chk("c_done_start", {31'b0, done_c}, 32'd0);
      m = 32'hFFFF_FFFF;
      for (int k = 1; k <= 64; k++) begin
         data_c = rand128();
         @(posedge clk); #1;
      end
      chk("c_warm_sig_hold", sig_c, 32'hFFFF_FFFF);
      for (int k = 0; k < 1024; k++) begin
         d       = rand128();
         data_c  = d;
         start_c = (k == mid_start_at);
         reset   = (k == rst_at);
         @(posedge clk); #1;
         start_c = 1'b0;
         if (k == rst_at) begin
            reset = 1'b0;
            chk("c_rst_sig", sig_c, 32'hFFFF_FFFF);
            chk("c_rst_busy", {31'b0, busy_c}, 32'd0);
            chk("c_rst_done", {31'b0, done_c}, 32'd0);
            chk("c_rst_cnt", {16'b0, cnt_c}, 32'd0);
            repeat (3) begin
               data_c = rand128();
               @(posedge clk); #1;
            end
            chk("c_rst_stay_idle", {31'b0, busy_c}, 32'd0);
            chk("c_rst_idle_sig", sig_c, 32'hFFFF_FFFF);
            return;
         end
         m = ref_step(m, ref_fold(d));
         if (k == mid_start_at) begin
            chk("c_mid_start_cnt", {16'b0, cnt_c}, k + 1);
            chk("c_mid_start_busy", {31'b0, busy_c}, 32'd1);
         end
      end
      sb_q.push_back(m);
      for (int w = 0; w < 4 && !done_c; w++) begin
         @(posedge clk); #1;
      end
      chk("c_done", {31'b0, done_c}, 32'd1);
      chk("c_busy_end", {31'b0, busy_c}, 32'd0);
      chk("c_cnt_end", {16'b0, cnt_c}, 32'd1023);
      if (sb_q.size() != 0) chk("c_signature", sig_c, sb_q.pop_front());
   endtask

   initial begin
      int n;
      logic [31:0] held;
      reset   = 1'b1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      data_a  = '0;   data_b  = '0;   data_c  = '0;

      //             rst   st    data                                         sig           busy  done  cnt
      tbl[0] = '{1'b0, 1'b0, 128'h0,                                     32'h0000_0000, 1'b0, 1'b0, 16'd0};
      tbl[1] = '{1'b0, 1'b1, 128'h5,                                     32'h0000_0000, 1'b1, 1'b0, 16'd0};
      tbl[2] = '{1'b0, 1'b0, 128'h1,                                     32'h0000_0001, 1'b1, 1'b0, 16'd1};
      tbl[3] = '{1'b0, 1'b0, 128'h0,                                     32'h0000_0003, 1'b0, 1'b1, 16'd1};
      tbl[4] = '{1'b0, 1'b0, {128{1'b1}},                                32'h0000_0003, 1'b0, 1'b1, 16'd1};
      tbl[5] = '{1'b0, 1'b1, {128{1'b1}},                                32'h0000_0000, 1'b1, 1'b0, 16'd0};
      tbl[6] = '{1'b0, 1'b1, {32'h0, 32'h0, 32'h1, 32'h0},               32'h0000_0001, 1'b1, 1'b0, 16'd1};
      tbl[7] = '{1'b0, 1'b0, {32'h1, 32'h0, 32'h0, 32'h1},               32'h0000_0003, 1'b0, 1'b1, 16'd1};
      tbl[8] = '{1'b1, 1'b1, 128'h7,                                     32'h0000_0000, 1'b0, 1'b0, 16'd0};
      tbl[9] = '{1'b0, 1'b0, 128'h0,                                     32'h0000_0000, 1'b0, 1'b0, 16'd0};

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_sig_c", sig_c, 32'hFFFF_FFFF);
      chk("reset_busy_c", {31'b0, busy_c}, 32'd0);
      chk("reset_done_c", {31'b0, done_c}, 32'd0);
      chk("reset_cnt_c", {16'b0, cnt_c}, 32'd0);

      // Table-driven short run instance
      for (int i = 0; i < 10; i++) begin
         reset   = tbl[i].rst;
         start_a = tbl[i].st;
         data_a  = tbl[i].d;
         @(posedge clk); #1;
         reset   = 1'b0;
         start_a = 1'b0;
         chk($sformatf("a_sig[%0d]", i), sig_a, tbl[i].sig);
         chk($sformatf("a_busy[%0d]", i), {31'b0, busy_a}, {31'b0, tbl[i].busy});
         chk($sformatf("a_done[%0d]", i), {31'b0, done_a}, {31'b0, tbl[i].done});
         chk($sformatf("a_cnt[%0d]", i), {16'b0, cnt_a}, {16'b0, tbl[i].cnt});
      end

      // Zero-seed instance: warmup garbage is ignored, zeros compact to zero
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         data_b = rand128();
         @(posedge clk); #1;
         if (k == 63) chk("b_warm_cnt", {16'b0, cnt_b}, 32'd63);
      end
      chk("b_compact_cnt0", {16'b0, cnt_b}, 32'd0);
      chk("b_warm_sig", sig_b, 32'h0);
      data_b = '0;
      n = 0;
      while (!done_b && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b_compact_cycles", n, 32'd1024);
      chk("b_signature", sig_b, 32'h0);
      chk("b_busy_end", {31'b0, busy_b}, 32'd0);

      // Default instance: plain run, held DONE, back-to-back, mid-start, reset
      run_c(-1, -1);
      held = sig_c;
      data_c = rand128();
      @(posedge clk); #1;
      chk("c_done_hold_sig", sig_c, held);
      chk("c_done_hold", {31'b0, done_c}, 32'd1);
      run_c(-1, 300);
      run_c(500, -1);
      run_c(-1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
